// File: rtl/inferencia_it2.sv
// Interval type-2 inference over a 3x3 rule base, one rule per clock.
// A frame snapshots the 12 input degrees, folds nine min/max rules into three consequents, then publishes them.
module inferencia_it2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         EN_SCLK,
  input  logic [W-1:0] A1_UP,
  input  logic [W-1:0] A2_UP,
  input  logic [W-1:0] A3_UP,
  input  logic [W-1:0] A1_LOW,
  input  logic [W-1:0] A2_LOW,
  input  logic [W-1:0] A3_LOW,
  input  logic [W-1:0] B1_UP,
  input  logic [W-1:0] B2_UP,
  input  logic [W-1:0] B3_UP,
  input  logic [W-1:0] B1_LOW,
  input  logic [W-1:0] B2_LOW,
  input  logic [W-1:0] B3_LOW,
  output logic [W-1:0] FOU_1_UP,
  output logic [W-1:0] FOU_2_UP,
  output logic [W-1:0] FOU_3_UP,
  output logic [W-1:0] FOU_1_LOW,
  output logic [W-1:0] FOU_2_LOW,
  output logic [W-1:0] FOU_3_LOW,
  output logic         busy,
  output logic         valid
);

  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

  state_t state, state_nxt;
  logic [3:0] rule_idx;
  logic       start;

  logic [2:0][W-1:0] a_up, a_low, b_up, b_low;
  logic [2:0][W-1:0] acc_up, acc_low;
  logic [2:0][W-1:0] fou_up, fou_low;

  logic [1:0] i_sel, j_sel, k_sel;
  logic [2:0] s_sum;
  logic [W-1:0] rule_up, rule_lo_raw, rule_lo;

  assign start = (state == IDLE) && EN_SCLK;
  assign busy  = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: the default assignment first keeps this block purely combinational (no latch inferred).
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (EN_SCLK) state_nxt = EVAL;
      EVAL:    if (rule_idx == 4'd8) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: the snapshot has no reset; it is always overwritten at the trigger edge before any rule reads it.
  always_ff @(posedge clk) begin
    if (start) begin
      a_up  <= {A3_UP,  A2_UP,  A1_UP};
      a_low <= {A3_LOW, A2_LOW, A1_LOW};
      b_up  <= {B3_UP,  B2_UP,  B1_UP};
      b_low <= {B3_LOW, B2_LOW, B1_LOW};
    end
  end

  // Rule r maps to A set i = r/3 and B set j = r%3.
  always_comb begin
    i_sel = 2'd0;
    j_sel = 2'd0;
    case (rule_idx)
      4'd1:    j_sel = 2'd1;
      4'd2:    j_sel = 2'd2;
      4'd3:    i_sel = 2'd1;
      4'd4:    begin i_sel = 2'd1; j_sel = 2'd1; end
      4'd5:    begin i_sel = 2'd1; j_sel = 2'd2; end
      4'd6:    i_sel = 2'd2;
      4'd7:    begin i_sel = 2'd2; j_sel = 2'd1; end
      4'd8:    begin i_sel = 2'd2; j_sel = 2'd2; end
      default: ;
    endcase
  end

  always_comb begin
    s_sum       = {1'b0, i_sel} + {1'b0, j_sel};
    k_sel       = (s_sum <= 3'd1) ? 2'd0 : (s_sum == 3'd2) ? 2'd1 : 2'd2;
    rule_up     = (a_up[i_sel]  < b_up[j_sel])  ? a_up[i_sel]  : b_up[j_sel];
    rule_lo_raw = (a_low[i_sel] < b_low[j_sel]) ? a_low[i_sel] : b_low[j_sel];
    // Malformed inputs (lower above upper) are clamped so the interval stays ordered.
    rule_lo     = (rule_lo_raw > rule_up) ? rule_up : rule_lo_raw;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rule_idx <= 4'd0;
      acc_up   <= '0;
      acc_low  <= '0;
      fou_up   <= '0;
      fou_low  <= '0;
      valid    <= 1'b0;
    end else begin
      valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (EN_SCLK) begin
            rule_idx <= 4'd0;
            acc_up   <= '0;
            acc_low  <= '0;
          end
        end
        EVAL: begin
          if (rule_up > acc_up[k_sel]) acc_up[k_sel]  <= rule_up;
          if (rule_lo > acc_low[k_sel]) acc_low[k_sel] <= rule_lo;
          if (rule_idx != 4'd8) rule_idx <= rule_idx + 4'd1;
        end
        DONE: begin
          fou_up  <= acc_up;
          fou_low <= acc_low;
          valid   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign {FOU_3_UP,  FOU_2_UP,  FOU_1_UP}  = fou_up;
  assign {FOU_3_LOW, FOU_2_LOW, FOU_1_LOW} = fou_low;

endmodule
